imem_boot: RTL and testbench
============================

# imem_boot

Parametrised, writable instruction memory for the pipelined CPU's IF stage. It replaces the hard-coded instruction ROM with a synchronous-read RAM. A byte-serial boot loader fills the RAM at run time. Fetch is stall-aware, and addresses outside the array read as NOP.

## Interface
Parameters:
- ADDR_BITS, 7: word-address width; DEPTH = 2^ADDR_BITS words.
- DATA_W, 32: instruction width; must be a multiple of 8; BYTES = DATA_W/8.
- NOP_WORD, 0: value returned for out-of-range or blocked fetches.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- if_addr  in  32  byte address from PC; bits [1:0] ignored for indexing.
- if_en  in  1  1 = advance fetch register; 0 = stall (hold outputs).
- if_data  out  DATA_W  registered instruction.
- if_valid  out  1  if_data holds a real array read.
- if_misalign  out  1  registered if_addr[1:0] != 0 for the fetch in if_data.
- if_perr  out  1  registered parity error for the fetch in if_data.
- ld_start  in  1  one-cycle pulse; begins a load when idle.
- ld_base  in  ADDR_BITS  first word index, sampled on accepted ld_start.
- ld_count  in  ADDR_BITS+1  words to load, sampled on accepted ld_start.
- ld_byte  in  8  load data byte.
- ld_byte_valid  in  1  ld_byte is valid this cycle.
- ld_ready  out  1  1 while in LOAD; bytes are accepted only when it is high.
- ld_done  out  1  one-cycle pulse when a load completes.
- busy  out  1  1 while in LOAD.

## Operation
- FSM states: IDLE, LOAD.
- IDLE to LOAD on ld_start. Latch ptr = ld_base, remaining = ld_count, byte_idx = 0.
- If ld_count = 0, stay in IDLE and pulse ld_done in the next cycle.
- ld_start is ignored while in LOAD. ld_byte_valid is ignored while in IDLE.
- LOAD assembles bytes big-endian: the first byte goes to bits [DATA_W-1:DATA_W-8].
- On the BYTES-th accepted byte, the word is written to mem[ptr]. Then ptr = ptr+1 modulo DEPTH (wraps), remaining decrements, and byte_idx clears.
- When remaining reaches 0 on a write, go to IDLE and pulse ld_done in the cycle after the final write.
- Fetch index is if_addr[ADDR_BITS+1:2].
- Out of range means if_addr[31:ADDR_BITS+2] != 0. Such a fetch loads if_data = NOP_WORD, if_valid = 0, if_perr = 0.
- During LOAD, fetches with if_en=1 load if_data = NOP_WORD and if_valid = 0.
- if_misalign is always registered from if_addr[1:0], including during LOAD.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - Outputs: if_data = NOP_WORD; if_valid, if_misalign, if_perr, ld_done, busy, ld_ready = 0.
  - Internal state: FSM = IDLE; ptr, remaining, byte_idx and the partial word = 0.
- Fetch latency is 1 cycle. if_addr sampled at edge N appears on if_data after edge N.
- Stall: with if_en=0, all if_* outputs hold their values.
- Write-to-read:
  - The final write commits at edge W, and the FSM is IDLE after W.
  - A fetch sampled at W+1 returns the new word.
  - No read-during-write bypass is needed, because fetches are blocked during LOAD.
- Reset during LOAD:
  - The load is aborted and ld_done is not pulsed.
  - Words already written stay written; the partial word is discarded.
- Throughput: one byte per cycle, so one word per BYTES cycles.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word stores one extra even-parity bit, computed over the written word.
  - On a fetch from the array, if_perr = 1 when the stored bit mismatches the recomputed parity.
  - if_valid is unaffected by a parity error.
- IMEM_PARITY_EN undefined: no parity storage; if_perr is tied to 0.

## Test plan
- Reset then fetch: reset high mid-cycle, release, fetch 0x0 with if_en=1. Required: if_data = 0x00000000 and if_valid = 1 (array holds X/0 per simulator init, so the bench preloads first). No output is X after reset.
- Load and read back: ld_start with ld_base=3, ld_count=2; bytes 8C,22,00,20,00,08,48,25. Required:
  - ld_done pulses one cycle after the 8th byte.
  - Fetch 0x0C returns 0x8C220020; fetch 0x10 returns 0x00084825.
- Wrap-around: ld_base=127, ld_count=2 (ADDR_BITS=7). Required: the first word lands at index 127 and the second at index 0; fetches 0x1FC and 0x000 confirm.
- Blocked, stalled and out-of-range fetch:
  - During LOAD, fetch 0x0: if_valid = 0 and if_data = NOP_WORD.
  - if_en=0 for 3 cycles: outputs hold.
  - if_addr = 0x400: if_valid = 0 and if_data = 0.
- Abort and misalign:
  - Assert reset after 5 of 8 bytes: word 0 is retained, word 1 is unchanged, no ld_done.
  - Fetch 0x06: if_misalign = 1, and if_data equals word 1.
- Parity (IMEM_PARITY_EN): force-flip a bit of stored word 3, then fetch 0x0C. Required: if_perr = 1 and if_valid = 1. With the macro off, if_perr = 0.

Source files
------------

// File: rtl/imem_boot.sv
// Writable instruction memory for the IF stage, filled at run time by a byte-serial boot loader.
// Define IMEM_PARITY_EN to store one even-parity bit per word and report mismatches on if_perr.
module imem_boot #(
    parameter int                ADDR_BITS = 7,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          if_addr,
    input  logic                 if_en,
    output logic [DATA_W-1:0]    if_data,
    output logic                 if_valid,
    output logic                 if_misalign,
    output logic                 if_perr,
    input  logic                 ld_start,
    input  logic [ADDR_BITS-1:0] ld_base,
    input  logic [ADDR_BITS:0]   ld_count,
    input  logic [7:0]           ld_byte,
    input  logic                 ld_byte_valid,
    output logic                 ld_ready,
    output logic                 ld_done,
    output logic                 busy
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;
    localparam logic [ADDR_BITS:0]   REM_ONE = 1;
    localparam logic [IDX_W-1:0]     IDX_ONE = 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(BYTES - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t               state_reg;
    logic [ADDR_BITS-1:0] ptr_reg;
    logic [ADDR_BITS:0]   remaining_reg;
    logic [IDX_W-1:0]     byte_idx_reg;
    logic [DATA_W-1:0]    word_reg;

    logic [MEM_W-1:0]     mem [DEPTH];

    logic                 byte_take;
    logic                 last_byte;
    logic                 mem_we;
    logic [DATA_W-1:0]    wr_word;
    logic [MEM_W-1:0]     wr_entry;
    logic [ADDR_BITS-1:0] rd_idx;
    logic                 rd_oor;
    logic [MEM_W-1:0]     rd_entry;
    logic                 rd_perr;

    assign byte_take = (state_reg == LOAD) && ld_byte_valid;
    assign last_byte = (byte_idx_reg == IDX_LAST);
    assign mem_we    = byte_take && last_byte;

    // Big-endian assembly: earlier bytes shift toward the MSB end.
    generate
        if (BYTES == 1) begin : g_one_byte
            assign wr_word = ld_byte;
        end else begin : g_multi_byte
            assign wr_word = {word_reg[DATA_W-9:0], ld_byte};
        end
    endgenerate

    assign rd_idx   = if_addr[ADDR_BITS+1:2];
    assign rd_oor   = (if_addr >> (ADDR_BITS + 2)) != 32'd0;
    assign rd_entry = mem[rd_idx];

`ifdef IMEM_PARITY_EN
    assign wr_entry = {^wr_word, wr_word};
    assign rd_perr  = rd_entry[DATA_W] ^ (^rd_entry[DATA_W-1:0]);
`else
    assign wr_entry = wr_word;
    assign rd_perr  = 1'b0;
`endif

    // No reset on the array: contents survive a reset that aborts a load.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            byte_idx_reg  <= '0;
            word_reg      <= '0;
            ld_done       <= 1'b0;
            ld_ready      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (ld_start) begin
                        ptr_reg       <= ld_base;
                        remaining_reg <= ld_count;
                        byte_idx_reg  <= '0;
                        word_reg      <= '0;
                        if (ld_count == '0) begin
                            ld_done <= 1'b1;
                        end else begin
                            state_reg <= LOAD;
                            ld_ready  <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (byte_take) begin
                        if (last_byte) begin
                            byte_idx_reg  <= '0;
                            word_reg      <= '0;
                            ptr_reg       <= ptr_reg + PTR_ONE;
                            remaining_reg <= remaining_reg - REM_ONE;
                            if (remaining_reg == REM_ONE) begin
                                state_reg <= IDLE;
                                ld_ready  <= 1'b0;
                                busy      <= 1'b0;
                                ld_done   <= 1'b1;
                            end
                        end else begin
                            byte_idx_reg <= byte_idx_reg + IDX_ONE;
                            word_reg     <= wr_word;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Fetch register; fetches while loading are blocked so no write bypass is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_data     <= NOP_WORD;
            if_valid    <= 1'b0;
            if_misalign <= 1'b0;
            if_perr     <= 1'b0;
        end else if (if_en) begin
            if_misalign <= (if_addr[1:0] != 2'b00);
            if ((state_reg == LOAD) || rd_oor) begin
                if_data  <= NOP_WORD;
                if_valid <= 1'b0;
                if_perr  <= 1'b0;
            end else begin
                if_data  <= rd_entry[DATA_W-1:0];
                if_valid <= 1'b1;
                if_perr  <= rd_perr;
            end
        end
    end
endmodule

// File: tb/tb_imem_boot.sv
// Directed bench for imem_boot: loads through the boot port, fetches checked against a
// scoreboard fed from a reference memory image kept by the bench.
module tb_imem_boot;
    logic        clk;
    logic        reset;
    logic [31:0] if_addr;
    logic        if_en;
    logic [31:0] if_data;
    logic        if_valid;
    logic        if_misalign;
    logic        if_perr;
    logic        ld_start;
    logic [6:0]  ld_base;
    logic [7:0]  ld_count;
    logic [7:0]  ld_byte;
    logic        ld_byte_valid;
    logic        ld_ready;
    logic        ld_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        valid;
        logic        mis;
        logic        perr;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    logic [31:0] model [128];

    imem_boot #(.ADDR_BITS(7), .DATA_W(32), .NOP_WORD(32'h0)) dut (
        .clk(clk), .reset(reset),
        .if_addr(if_addr), .if_en(if_en), .if_data(if_data), .if_valid(if_valid),
        .if_misalign(if_misalign), .if_perr(if_perr),
        .ld_start(ld_start), .ld_base(ld_base), .ld_count(ld_count),
        .ld_byte(ld_byte), .ld_byte_valid(ld_byte_valid),
        .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_data"}, if_data, 32'h0);
        chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_mis"}, {31'd0, if_misalign}, 32'd0);
        chk({tag, "_perr"}, {31'd0, if_perr}, 32'd0);
        chk({tag, "_done"}, {31'd0, ld_done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, ld_ready}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] addr, input string tag, input logic exp_perr);
        exp_t e;
        exp_t got;
        logic in_range;
        logic [6:0] idx;
        in_range = (addr >> 9) == 32'd0;
        idx      = addr[8:2];
        e.data   = in_range ? model[idx] : 32'h0;
        e.valid  = in_range;
        e.mis    = addr[1:0] != 2'b00;
        e.perr   = in_range ? exp_perr : 1'b0;
        e.tag    = tag;
        sb.push_back(e);
        if_addr = addr;
        if_en   = 1'b1;
        tick();
        if_en = 1'b0;
        got = sb.pop_front();
        chk({got.tag, "_data"}, if_data, got.data);
        chk({got.tag, "_valid"}, {31'd0, if_valid}, {31'd0, got.valid});
        chk({got.tag, "_mis"}, {31'd0, if_misalign}, {31'd0, got.mis});
        chk({got.tag, "_perr"}, {31'd0, if_perr}, {31'd0, got.perr});
        $display("fetch %s addr=%h data=%h valid=%0b mis=%0b perr=%0b",
                 got.tag, addr, if_data, if_valid, if_misalign, if_perr);
        last_exp = got;
    endtask

    task automatic load(input int base, input int cnt, input logic [7:0] bytes[$],
                        input bit blk, input int gap_at);
        ld_base  = 7'(base);
        ld_count = 8'(cnt);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        if (cnt == 0) begin
            chk("zero_done", {31'd0, ld_done}, 32'd1);
            chk("zero_busy", {31'd0, busy}, 32'd0);
            tick();
            chk("zero_done_pulse", {31'd0, ld_done}, 32'd0);
            $display("load base=%0d count=0 done", base);
            return;
        end
        chk("ld_busy", {31'd0, busy}, 32'd1);
        chk("ld_ready", {31'd0, ld_ready}, 32'd1);
        for (int i = 0; i < bytes.size(); i++) begin
            if (i == gap_at) begin
                ld_byte_valid = 1'b0;
                tick();
            end
            ld_byte       = bytes[i];
            ld_byte_valid = 1'b1;
            if_en         = blk;
            if_addr       = 32'h0;
            tick();
            ld_byte_valid = 1'b0;
            if_en         = 1'b0;
            if (blk) begin
                chk("blocked_valid", {31'd0, if_valid}, 32'd0);
                chk("blocked_data", if_data, 32'h0);
            end
            if (i < bytes.size() - 1) chk("early_done", {31'd0, ld_done}, 32'd0);
        end
        for (int w = 0; w < cnt; w++) begin
            model[(base + w) % 128] = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
        end
        chk("ld_done", {31'd0, ld_done}, 32'd1);
        chk("ld_busy_end", {31'd0, busy}, 32'd0);
        chk("ld_ready_end", {31'd0, ld_ready}, 32'd0);
        tick();
        chk("ld_done_pulse", {31'd0, ld_done}, 32'd0);
        $display("load base=%0d count=%0d done", base, cnt);
    endtask

    initial begin
        reset = 1'b0; if_addr = 32'h0; if_en = 1'b0;
        ld_start = 1'b0; ld_base = '0; ld_count = '0; ld_byte = '0; ld_byte_valid = 1'b0;

        // Asynchronous reset asserted mid-cycle, before any clock edge.
        #3 reset = 1'b1;
        #1 chk_idle_outputs("reset_async");
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_idle_outputs("reset_release");

        load(0, 2, '{8'h00, 8'h00, 8'h00, 8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D}, 1'b0, -1);
        fetch(32'h0, "preload_w0", 1'b0);

        load(3, 0, '{}, 1'b0, -1);

        // Blocked fetches of 0x0 while the two-word program loads.
        load(3, 2, '{8'h8C, 8'h22, 8'h00, 8'h20, 8'h00, 8'h08, 8'h48, 8'h25}, 1'b1, -1);
        fetch(32'h0C, "rd_w3", 1'b0);
        chk("rd_w3_const", last_exp.data, 32'h8C220020);
        fetch(32'h10, "rd_w4", 1'b0);
        chk("rd_w4_const", last_exp.data, 32'h00084825);

        // Stray byte in IDLE must be ignored; gap in the byte stream mid-word.
        ld_byte = 8'hFF; ld_byte_valid = 1'b1; tick(); ld_byte_valid = 1'b0;
        load(127, 2, '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78}, 1'b0, 3);
        fetch(32'h1FC, "wrap_w127", 1'b0);
        chk("wrap_w127_const", last_exp.data, 32'hDEADBEEF);
        fetch(32'h000, "wrap_w0", 1'b0);
        chk("wrap_w0_const", last_exp.data, 32'h12345678);

        fetch(32'h0C, "pre_stall", 1'b0);
        if_addr = 32'h13;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_data", if_data, last_exp.data);
            chk("stall_valid", {31'd0, if_valid}, {31'd0, last_exp.valid});
            chk("stall_mis", {31'd0, if_misalign}, {31'd0, last_exp.mis});
            $display("stall cycle %0d data=%h", c, if_data);
        end

        fetch(32'h400, "oor_400", 1'b0);
        fetch(32'h8000000C, "oor_high", 1'b0);

        // Abort: reset after five bytes of a two-word load at base 0.
        ld_base = 7'd0; ld_count = 8'd2; ld_start = 1'b1; tick(); ld_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ld_byte = 8'(i); ld_byte_valid = 1'b1; tick(); ld_byte_valid = 1'b0;
            chk("abort_no_done", {31'd0, ld_done}, 32'd0);
        end
        model[0] = 32'h01020304;
        #3 reset = 1'b1;
        #1 chk("abort_done_rst", {31'd0, ld_done}, 32'd0);
        chk("abort_busy_rst", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("abort_no_done_after", {31'd0, ld_done}, 32'd0);
        end
        $display("abort after 5 bytes");
        fetch(32'h00, "abort_w0", 1'b0);
        chk("abort_w0_const", last_exp.data, 32'h01020304);
        fetch(32'h06, "misalign_w1", 1'b0);
        chk("misalign_w1_const", last_exp.data, 32'hCAFEF00D);
        fetch(32'h04, "aligned_w1", 1'b0);

`ifdef IMEM_PARITY_EN
        dut.mem[3] = dut.mem[3] ^ 33'd1;
        model[3]   = model[3] ^ 32'd1;
        fetch(32'h0C, "parity_err", 1'b1);
`else
        fetch(32'h0C, "parity_off", 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
